// File: rtl/multdiv_scheduler_pkg.sv
// Shared definitions for the mult/div scheduler: FSM encoding, widths and
// default parameter values.
package md_defs;

    localparam int REG_W          = 5;
    localparam int CNT_W          = 6;
    localparam int DEF_TIMEOUT    = 40;
    localparam int DEF_STATUS_REG = 30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } md_state_e;

endpackage

// File: rtl/multdiv_scheduler_if.sv
// Bundle between the decode/execute pipeline (master) and the mult/div
// scheduler (slave).
//
// Handshake: the pipeline presents a request by holding ctrl_mult/ctrl_div
// high together with rd_dec. The scheduler takes it in any cycle where it is
// idle and flush is low; otherwise it raises stall and the pipeline keeps the
// request asserted unchanged until a cycle with stall low. md_start,
// md_ready and md_abort are single-cycle pulses with no back-pressure.
// wb_en is a one-cycle write strobe, qualified by wb_busy from the pipeline.
interface md_sched_if;
    import md_defs::*;

    logic             ctrl_mult;
    logic             ctrl_div;
    logic [REG_W-1:0] rd_dec;
    logic [REG_W-1:0] rs_a;
    logic [REG_W-1:0] rs_b;
    logic             flush;
    logic             md_ready;
    logic             md_exc;
    logic             wb_busy;

    logic             md_start;
    logic             md_is_div;
    logic             md_abort;
    logic             stall;
    logic             wb_en;
    logic [REG_W-1:0] wb_rd;
    logic             wb_exc;
    logic             busy;

    modport master (
        output ctrl_mult, ctrl_div, rd_dec, rs_a, rs_b, flush,
               md_ready, md_exc, wb_busy,
        input  md_start, md_is_div, md_abort, stall, wb_en, wb_rd,
               wb_exc, busy
    );

    modport slave (
        input  ctrl_mult, ctrl_div, rd_dec, rs_a, rs_b, flush,
               md_ready, md_exc, wb_busy,
        output md_start, md_is_div, md_abort, stall, wb_en, wb_rd,
               wb_exc, busy
    );

endinterface

// File: rtl/multdiv_scheduler_counter.sv
// Run-time counter for the mult/div unit: saturates at all-ones instead of
// wrapping so a stuck unit can never alias back to a small count.
module md_cycle_counter
    import md_defs::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Clear has priority over counting; hold once saturated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/multdiv_scheduler.sv
// Scheduler for the shared iterative mult/div unit: accepts one op at a time,
// launches the unit, bounds its run time, tracks the pending destination for
// hazard stalls and hands the result to the register-file write port.
// TIMEOUT must be at least 2.
module multdiv_scheduler
    import md_defs::*;
#(
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int STATUS_REG = DEF_STATUS_REG
) (
    input  logic       clock,
    input  logic       reset,
    md_sched_if.slave  bus,
    output md_state_e  o_dbg_state
);

    md_state_e        r_state;
    md_state_e        w_next_state;

    logic [REG_W-1:0] r_pend_rd;
    logic             r_is_div;
    logic             r_md_start;
    logic [REG_W-1:0] r_wb_rd;
    logic             r_wb_exc;

    logic             w_accept;
    logic             w_abort;
    logic             w_wb_en;
    logic             w_enter_wb;
    logic             w_enter_exc;
    logic             w_leave;
    logic             w_request;
    logic             w_hazard;
    logic             w_timeout;
    logic [CNT_W-1:0] w_count;

    md_cycle_counter u_counter (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_clr   (w_accept),
        .i_en    (r_state == ST_RUN),
        .o_count (w_count)
    );

    assign w_request = bus.ctrl_mult | bus.ctrl_div;
    assign w_timeout = (w_count == CNT_W'(TIMEOUT - 1));

    // RAW/WAW check of the decoding instruction against the outstanding
    // destination; r0 is never a real dependency.
    assign w_hazard  = (r_pend_rd != '0) &&
                       ((bus.rd_dec == r_pend_rd) ||
                        (bus.rs_a   == r_pend_rd) ||
                        (bus.rs_b   == r_pend_rd));

    // Leaving an op for any reason (write done, skipped write, flush).
    assign w_leave   = (r_state != ST_IDLE) && (w_next_state == ST_IDLE);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and the combinational strobes; flush always dominates.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_abort      = 1'b0;
        w_wb_en      = 1'b0;
        w_enter_wb   = 1'b0;
        w_enter_exc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.flush && w_request) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (bus.md_ready) begin
                    w_enter_wb   = 1'b1;
                    w_enter_exc  = bus.md_exc;
                    w_next_state = ST_WB;
                end else if (w_timeout) begin
                    w_enter_wb   = 1'b1;
                    w_enter_exc  = 1'b1;
                    w_next_state = ST_WB;
                end
            end
            ST_WB: begin
                if (bus.flush) begin
                    w_next_state = ST_IDLE;
                end else if ((r_pend_rd == '0) && !r_wb_exc) begin
                    // Result targets r0: nothing to write.
                    w_next_state = ST_IDLE;
                end else if (!bus.wb_busy) begin
                    w_wb_en      = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Pending-op registers: launch pulse, op select and destination.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend_rd  <= '0;
            r_is_div   <= 1'b0;
            r_md_start <= 1'b0;
        end else begin
            r_md_start <= w_accept;
            if (w_accept) begin
                r_pend_rd <= bus.rd_dec;
                r_is_div  <= bus.ctrl_div & ~bus.ctrl_mult;
            end else if (w_leave) begin
                r_is_div  <= 1'b0;
            end
        end
    end

    // Writeback mux, loaded on entry to WB and cleared when the op ends.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wb_rd  <= '0;
            r_wb_exc <= 1'b0;
        end else if (w_enter_wb) begin
            r_wb_rd  <= w_enter_exc ? REG_W'(STATUS_REG) : r_pend_rd;
            r_wb_exc <= w_enter_exc;
        end else if (w_leave) begin
            r_wb_rd  <= '0;
            r_wb_exc <= 1'b0;
        end
    end

    assign bus.md_start  = r_md_start;
    assign bus.md_is_div = r_is_div;
    assign bus.md_abort  = w_abort;
    assign bus.wb_en     = w_wb_en;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_exc    = r_wb_exc;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.stall     = bus.busy && (w_request || w_hazard);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed bench for multdiv_scheduler. Inputs change 1 ns after the rising
// edge; outputs are examined 1 ns later, well away from the next edge.
module tb_multdiv_scheduler;
    import md_defs::*;

    logic      clock;
    logic      reset;
    md_state_e dbg_state;
    int        total;
    int        bad;

    md_sched_if bus();

    multdiv_scheduler #(
        .TIMEOUT    (40),
        .STATUS_REG (30)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.ctrl_mult = 1'b0;
        bus.ctrl_div  = 1'b0;
        bus.rd_dec    = '0;
        bus.rs_a      = '0;
        bus.rs_b      = '0;
        bus.flush     = 1'b0;
        bus.md_ready  = 1'b0;
        bus.md_exc    = 1'b0;
        bus.wb_busy   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one cycle; returns in RUN cycle 0.
    task automatic launch(input logic m, input logic d, input logic [4:0] rd);
        bus.ctrl_mult = m;
        bus.ctrl_div  = d;
        bus.rd_dec    = rd;
        tick();
        bus.ctrl_mult = 1'b0;
        bus.ctrl_div  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        bus.ctrl_mult = 1'b1;
        #1;
        total++; if ({bus.md_start, bus.md_is_div, bus.md_abort, bus.stall, bus.wb_en, bus.wb_rd, bus.wb_exc, bus.busy} !== 12'd0) begin bad++; $display("FAIL reset_outputs got=%b exp=0", {bus.md_start, bus.md_is_div, bus.md_abort, bus.stall, bus.wb_en, bus.wb_rd, bus.wb_exc, bus.busy}); end
        tick();
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        clear_inputs();
        reset = 1'b1;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_mult();
        bus.ctrl_mult = 1'b1;
        bus.rd_dec    = 5'd5;
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL mult_accept_stall got=%0b exp=0", bus.stall); end
        tick();
        bus.ctrl_mult = 1'b0;
        #1;
        total++; if (bus.md_start !== 1'b1) begin bad++; $display("FAIL mult_start got=%0b exp=1", bus.md_start); end
        total++; if (bus.md_is_div !== 1'b0) begin bad++; $display("FAIL mult_is_div got=%0b exp=0", bus.md_is_div); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mult_busy got=%0b exp=1", bus.busy); end
        tick();
        total++; if (bus.md_start !== 1'b0) begin bad++; $display("FAIL mult_start_pulse got=%0b exp=0", bus.md_start); end
        repeat (16) tick();
        bus.md_ready = 1'b1;
        #1;
        total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL mult_wb_early got=%0b exp=0", bus.wb_en); end
        tick();
        bus.md_ready = 1'b0;
        #1;
        total++; if (bus.wb_en !== 1'b1) begin bad++; $display("FAIL mult_wb_en got=%0b exp=1", bus.wb_en); end
        total++; if (bus.wb_rd !== 5'd5) begin bad++; $display("FAIL mult_wb_rd got=%0d exp=5", bus.wb_rd); end
        total++; if (bus.wb_exc !== 1'b0) begin bad++; $display("FAIL mult_wb_exc got=%0b exp=0", bus.wb_exc); end
        tick();
        total++; if ({bus.busy, bus.wb_en} !== 2'b00) begin bad++; $display("FAIL mult_done got=%b exp=00", {bus.busy, bus.wb_en}); end
        clear_inputs();
    endtask

    task automatic test_div_exc();
        launch(1'b0, 1'b1, 5'd7);
        #1;
        total++; if (bus.md_is_div !== 1'b1) begin bad++; $display("FAIL div_is_div_run got=%0b exp=1", bus.md_is_div); end
        repeat (3) tick();
        bus.md_ready = 1'b1;
        bus.md_exc   = 1'b1;
        tick();
        bus.md_ready = 1'b0;
        bus.md_exc   = 1'b0;
        #1;
        total++; if (bus.wb_en !== 1'b1) begin bad++; $display("FAIL div_wb_en got=%0b exp=1", bus.wb_en); end
        total++; if (bus.wb_rd !== 5'd30) begin bad++; $display("FAIL div_wb_rd got=%0d exp=30", bus.wb_rd); end
        total++; if (bus.wb_exc !== 1'b1) begin bad++; $display("FAIL div_wb_exc got=%0b exp=1", bus.wb_exc); end
        total++; if (bus.md_is_div !== 1'b1) begin bad++; $display("FAIL div_is_div_wb got=%0b exp=1", bus.md_is_div); end
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL div_done got=%0b exp=0", bus.busy); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        launch(1'b1, 1'b0, 5'd6);
        repeat (39) tick();
        #1;
        total++; if (dbg_state !== ST_RUN) begin bad++; $display("FAIL to_state_c39 got=%0d exp=%0d", dbg_state, ST_RUN); end
        total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL to_wb_early got=%0b exp=0", bus.wb_en); end
        tick();
        total++; if (dbg_state !== ST_WB) begin bad++; $display("FAIL to_state_wb got=%0d exp=%0d", dbg_state, ST_WB); end
        total++; if ({bus.wb_en, bus.wb_rd, bus.wb_exc} !== {1'b1, 5'd30, 1'b1}) begin bad++; $display("FAIL to_wb got=%b exp=%b", {bus.wb_en, bus.wb_rd, bus.wb_exc}, {1'b1, 5'd30, 1'b1}); end
        tick();
        // md_ready arriving in the timeout cycle takes priority.
        launch(1'b1, 1'b0, 5'd8);
        repeat (39) tick();
        bus.md_ready = 1'b1;
        tick();
        bus.md_ready = 1'b0;
        #1;
        total++; if ({bus.wb_en, bus.wb_rd, bus.wb_exc} !== {1'b1, 5'd8, 1'b0}) begin bad++; $display("FAIL to_ready_wins got=%b exp=%b", {bus.wb_en, bus.wb_rd, bus.wb_exc}, {1'b1, 5'd8, 1'b0}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_hazard();
        launch(1'b1, 1'b0, 5'd9);
        tick();
        bus.rd_dec = 5'd1;
        bus.rs_a   = 5'd4;
        bus.rs_b   = 5'd9;
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL haz_rs_b got=%0b exp=1", bus.stall); end
        bus.rs_b = 5'd3;
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL haz_none got=%0b exp=0", bus.stall); end
        bus.rd_dec = 5'd9;
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL haz_waw got=%0b exp=1", bus.stall); end
        bus.rd_dec   = 5'd1;
        bus.rs_b     = 5'd9;
        bus.md_ready = 1'b1;
        tick();
        bus.md_ready = 1'b0;
        #1;
        total++; if ({bus.wb_en, bus.stall} !== 2'b11) begin bad++; $display("FAIL haz_wb_cycle got=%b exp=11", {bus.wb_en, bus.stall}); end
        tick();
        total++; if ({bus.busy, bus.stall} !== 2'b00) begin bad++; $display("FAIL haz_release got=%b exp=00", {bus.busy, bus.stall}); end
        clear_inputs();
    endtask

    task automatic test_zero_rd();
        launch(1'b1, 1'b0, 5'd0);
        bus.md_ready = 1'b1;
        tick();
        bus.md_ready = 1'b0;
        #1;
        total++; if ({dbg_state, bus.wb_en} !== {ST_WB, 1'b0}) begin bad++; $display("FAIL r0_wb got=%b exp=%b", {dbg_state, bus.wb_en}, {ST_WB, 1'b0}); end
        tick();
        total++; if ({dbg_state, bus.wb_en} !== {ST_IDLE, 1'b0}) begin bad++; $display("FAIL r0_idle got=%b exp=%b", {dbg_state, bus.wb_en}, {ST_IDLE, 1'b0}); end
        clear_inputs();
    endtask

    task automatic test_wb_busy();
        int fires;
        fires = 0;
        launch(1'b1, 1'b0, 5'd12);
        tick();
        bus.md_ready = 1'b1;
        bus.wb_busy  = 1'b1;
        tick();
        bus.md_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.wb_en === 1'b1) fires++;
            total++; if ({bus.wb_en, bus.busy} !== 2'b01) begin bad++; $display("FAIL wbb_hold%0d got=%b exp=01", i, {bus.wb_en, bus.busy}); end
            tick();
        end
        bus.wb_busy = 1'b0;
        #1;
        if (bus.wb_en === 1'b1) fires++;
        total++; if ({bus.wb_en, bus.wb_rd} !== {1'b1, 5'd12}) begin bad++; $display("FAIL wbb_fire got=%b exp=%b", {bus.wb_en, bus.wb_rd}, {1'b1, 5'd12}); end
        tick();
        if (bus.wb_en === 1'b1) fires++;
        total++; if (fires !== 1) begin bad++; $display("FAIL wbb_fire_count got=%0d exp=1", fires); end
        clear_inputs();
    endtask

    task automatic test_flush();
        launch(1'b1, 1'b0, 5'd13);
        repeat (3) tick();
        bus.flush    = 1'b1;
        bus.md_ready = 1'b1;
        #1;
        total++; if ({bus.md_abort, bus.wb_en} !== 2'b10) begin bad++; $display("FAIL fl_run got=%b exp=10", {bus.md_abort, bus.wb_en}); end
        tick();
        bus.flush    = 1'b0;
        bus.md_ready = 1'b0;
        #1;
        total++; if ({bus.md_abort, bus.busy, bus.wb_en} !== 3'b000) begin bad++; $display("FAIL fl_run_after got=%b exp=000", {bus.md_abort, bus.busy, bus.wb_en}); end
        launch(1'b1, 1'b0, 5'd14);
        bus.md_ready = 1'b1;
        tick();
        bus.md_ready = 1'b0;
        bus.flush    = 1'b1;
        #1;
        total++; if ({bus.md_abort, bus.wb_en} !== 2'b00) begin bad++; $display("FAIL fl_wb got=%b exp=00", {bus.md_abort, bus.wb_en}); end
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL fl_wb_after got=%0b exp=0", bus.busy); end
        bus.ctrl_mult = 1'b1;
        bus.rd_dec    = 5'd15;
        tick();
        bus.ctrl_mult = 1'b0;
        bus.flush     = 1'b0;
        #1;
        total++; if ({bus.busy, bus.md_start} !== 2'b00) begin bad++; $display("FAIL fl_idle got=%b exp=00", {bus.busy, bus.md_start}); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        bus.ctrl_mult = 1'b1;
        bus.ctrl_div  = 1'b1;
        bus.rd_dec    = 5'd3;
        tick();
        bus.ctrl_mult = 1'b0;
        bus.rd_dec    = 5'd20;
        #1;
        total++; if ({bus.md_start, bus.md_is_div, bus.stall} !== 3'b101) begin bad++; $display("FAIL b2b_first got=%b exp=101", {bus.md_start, bus.md_is_div, bus.stall}); end
        tick();
        bus.md_ready = 1'b1;
        tick();
        bus.md_ready = 1'b0;
        #1;
        total++; if ({bus.wb_en, bus.wb_rd, bus.stall} !== {1'b1, 5'd3, 1'b1}) begin bad++; $display("FAIL b2b_wb got=%b exp=%b", {bus.wb_en, bus.wb_rd, bus.stall}, {1'b1, 5'd3, 1'b1}); end
        tick();
        total++; if ({bus.busy, bus.stall} !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b exp=00", {bus.busy, bus.stall}); end
        tick();
        bus.ctrl_div = 1'b0;
        #1;
        total++; if ({bus.md_start, bus.md_is_div, bus.busy} !== 3'b111) begin bad++; $display("FAIL b2b_second got=%b exp=111", {bus.md_start, bus.md_is_div, bus.busy}); end
        tick();
        tick();
        bus.ctrl_mult = 1'b1;
        reset = 1'b0;
        #1;
        total++; if ({bus.md_start, bus.md_is_div, bus.md_abort, bus.stall, bus.wb_en, bus.wb_rd, bus.wb_exc, bus.busy} !== 12'd0) begin bad++; $display("FAIL b2b_reset got=%b exp=0", {bus.md_start, bus.md_is_div, bus.md_abort, bus.stall, bus.wb_en, bus.wb_rd, bus.wb_exc, bus.busy}); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL b2b_reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_mult();
        test_div_exc();
        test_timeout();
        test_hazard();
        test_zero_rd();
        test_wb_busy();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
